// File: rtl/priority_mux_pkg.sv
// Shared definitions for priority selection logic.
// prio_onehot() turns a request vector into a one-hot (or all-zero) grant,
// bit 0 highest priority. Other arbiters can reuse it for vectors up to
// PRIO_MAX_CNT bits wide by zero-extending their requests.
package priority_mux_pkg;

  localparam int PRIO_MAX_CNT = 32;

  typedef logic [PRIO_MAX_CNT-1:0] prio_vec_t;

  // Walk from bit 0 upward; once any request has been seen, every later bit
  // is masked off. Bitwise ops keep an X on a masked bit from leaking out.
  function automatic prio_vec_t prio_onehot(input prio_vec_t sel);
    prio_vec_t grant;
    logic      seen;
    grant = '0;
    seen  = 1'b0;
    for (int i = 0; i < PRIO_MAX_CNT; i++) begin
      grant[i] = sel[i] & ~seen;
      seen     = seen | sel[i];
    end
    return grant;
  endfunction

endpackage

// File: rtl/prio_onehot_enc.sv
// Priority one-hot encoder: grant_o[i] = sel_i[i] & ~|sel_i[i-1:0].
// Output is one-hot when any request is high, all-zero otherwise.
module prio_onehot_enc
  import priority_mux_pkg::*;
#(
  parameter int CNT = 2
) (
  input  logic [CNT-1:0] sel_i,
  output logic [CNT-1:0] grant_o
);

  genvar gi;
  generate
    for (gi = 0; gi < CNT; gi++) begin : g_grant
      if (gi == 0) begin : g_first
        // Slot 0 has nothing above it and wins whenever it asks.
        assign grant_o[gi] = sel_i[gi];
      end else begin : g_rest
        // Any higher-priority request blocks this slot.
        assign grant_o[gi] = sel_i[gi] & ~(|sel_i[gi-1:0]);
      end
    end
  endgenerate

endmodule

// File: rtl/priority_sel_mux.sv
// N-way priority multiplexer: dout is the WIDTH-bit slice of din whose select
// bit is the lowest-indexed one that is high; all-zero when no select is high.
// hit reports whether any select is high.
// Build option PRIORITY_MUX_OUT_REG_EN: when defined, dout/hit are registered
// (one clock of latency, async-cleared by rst_n). When undefined the block is
// purely combinational and clk/rst_n are ignored.
module priority_sel_mux
  import priority_mux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH*CNT-1:0] din,
  input  logic [CNT-1:0]       sel,
  output logic [WIDTH-1:0]     dout,
  output logic                 hit
);

  // Degenerate sizes cannot form a slice or a select; stop at elaboration.
  if (WIDTH < 1 || CNT < 1) begin : g_bad_params
    $error("priority_sel_mux: WIDTH (%0d) and CNT (%0d) must both be >= 1", WIDTH, CNT);
  end

  logic [CNT-1:0]   grant;
  logic [WIDTH-1:0] masked [CNT];
  logic [WIDTH-1:0] dout_d;
  logic             hit_d;

  prio_onehot_enc #(
    .CNT (CNT)
  ) u_enc (
    .sel_i   (sel),
    .grant_o (grant)
  );

  // Gate each slice with its grant; at most one slice survives.
  genvar gi;
  generate
    for (gi = 0; gi < CNT; gi++) begin : g_mask
      assign masked[gi] = {WIDTH{grant[gi]}} & din[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // OR the gated slices together; with a one-hot grant this is a pure select.
  always_comb begin
    dout_d = '0;
    for (int i = 0; i < CNT; i++) begin
      dout_d = dout_d | masked[i];
    end
  end

  assign hit_d = |sel;

`ifdef PRIORITY_MUX_OUT_REG_EN
  logic [WIDTH-1:0] dout_q;
  logic             hit_q;

  // Output register; reset clears the outputs immediately, without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      hit_q  <= hit_d;
    end
  end

  assign dout = dout_q;
  assign hit  = hit_q;
`else
  // Combinational build: clock and reset are intentionally left unconnected.
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst_n};

  assign dout = dout_d;
  assign hit  = hit_d;
`endif

endmodule

// File: tb/tb_priority_sel_mux.sv
// Scoreboard bench for priority_sel_mux (8-bit slices; CNT = 2, 4 and 1).
// Stimulus pushes the expected response when it drives a vector; a monitor
// pops and compares on the falling edge when that vector's response is due.
// Works for both builds: with PRIORITY_MUX_OUT_REG_EN the response is due one
// edge later, and during reset the expected outputs are zero.
module tb_priority_sel_mux;

`ifdef PRIORITY_MUX_OUT_REG_EN
  localparam bit REG_BUILD = 1'b1;
`else
  localparam bit REG_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din2;
  logic [1:0]  sel2;
  logic [7:0]  dout2;
  logic        hit2;
  logic [31:0] din4;
  logic [3:0]  sel4;
  logic [7:0]  dout4;
  logic        hit4;
  logic [7:0]  din1;
  logic [0:0]  sel1;
  logic [7:0]  dout1;
  logic        hit1;

  always #5 clk = ~clk;

  priority_sel_mux #(.WIDTH(8), .CNT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .din(din2), .sel(sel2), .dout(dout2), .hit(hit2));
  priority_sel_mux #(.WIDTH(8), .CNT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .sel(sel4), .dout(dout4), .hit(hit4));
  priority_sel_mux #(.WIDTH(8), .CNT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .sel(sel1), .dout(dout1), .hit(hit1));

  typedef struct {
    int         unit;
    bit         imm;
    logic [7:0] exp_dout;
    logic       exp_hit;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  bit   issued   = 1'b0;  // a normal vector was driven this cycle
  bit   issued_q = 1'b0;  // ...in the previous cycle (register build timing)
  bit   probe    = 1'b0;  // immediate check, independent of build latency
  bit   done     = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) issued_q <= issued;

  // Drive one vector to the chosen unit and record what it must produce.
  task automatic apply(input int unit, input logic [31:0] d, input logic [3:0] s,
                       input logic [7:0] ed, input logic eh, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    case (unit)
      2:       begin din2 = d[15:0]; sel2 = s[1:0]; end
      4:       begin din4 = d;       sel4 = s;      end
      default: begin din1 = d[7:0];  sel1 = s[0:0]; end
    endcase
    e.unit = unit; e.imm = 1'b0; e.exp_dout = ed; e.exp_hit = eh; e.name = name;
    sb_q.push_back(e);
    issued = 1'b1;
    probe  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    issued = 1'b0;
    probe  = 1'b0;
  endtask

  // Check unit outputs in the same cycle, optionally changing rst_n first.
  task automatic probe_chk(input int unit, input logic rst_val,
                           input logic [7:0] ed, input logic eh, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst_val;
    e.unit = unit; e.imm = 1'b1; e.exp_dout = ed; e.exp_hit = eh; e.name = name;
    sb_q.push_back(e);
    issued = 1'b0;
    probe  = 1'b1;
  endtask

  // Monitor: compare whenever a response is due; also owns the summary.
  initial begin : monitor
    exp_t       e;
    logic [7:0] act_d;
    logic       act_h;
    bit         due;
    forever begin
      @(negedge clk);
      if (done) begin
        n_checks++;
        if (sb_q.size() != 0) begin
          n_errors++;
          $display("FAIL drain: %0d responses never observed, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
      end
      due = probe || (REG_BUILD ? issued_q : issued);
      if (due) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL scoreboard: output due but nothing expected");
        end else begin
          e = sb_q.pop_front();
          case (e.unit)
            2:       begin act_d = dout2; act_h = hit2; end
            4:       begin act_d = dout4; act_h = hit4; end
            default: begin act_d = dout1; act_h = hit1; end
          endcase
          n_checks++;
          if (act_d !== e.exp_dout || act_h !== e.exp_hit) begin
            n_errors++;
            $display("FAIL %s: dout=%h hit=%b, required dout=%h hit=%b",
                     e.name, act_d, act_h, e.exp_dout, e.exp_hit);
          end else begin
            $display("ok   %s: dout=%h hit=%b", e.name, act_d, act_h);
          end
        end
      end
    end
  end

  // Stimulus.
  initial begin : stim
    logic [3:0] sel_x;
    rst_n = 1'b0;
    din2  = {8'hA5, 8'h3C};
    sel2  = 2'b10;
    din4  = {8'h44, 8'h33, 8'h22, 8'h11};
    sel4  = 4'b0000;
    din1  = 8'h5A;
    sel1  = 1'b0;

    // Reset state: registered outputs cleared, combinational outputs follow inputs.
    probe_chk(2, 1'b0, REG_BUILD ? 8'h00 : 8'hA5, REG_BUILD ? 1'b0 : 1'b1, "reset_state");
    probe_chk(4, 1'b0, 8'h00, 1'b0, "reset_state_cnt4");
    idle();
    rst_n = 1'b1;

    // CNT=2 directed vectors.
    apply(2, {16'h0, 8'hA5, 8'h3C}, 4'b0000, 8'h00, 1'b0, "c2_sel00");
    apply(2, {16'h0, 8'hA5, 8'h3C}, 4'b0001, 8'h3C, 1'b1, "c2_sel01");
    apply(2, {16'h0, 8'hA5, 8'h3C}, 4'b0010, 8'hA5, 1'b1, "c2_sel10");
    apply(2, {16'h0, 8'hA5, 8'h3C}, 4'b0011, 8'h3C, 1'b1, "c2_sel11_slot0_wins");
    apply(2, {16'h0, 8'hFF, 8'h00}, 4'b0011, 8'h00, 1'b1, "c2_zero_slice_no_or");
    apply(2, {16'h0, 8'hFF, 8'h00}, 4'b0010, 8'hFF, 1'b1, "c2_sel10_ff");

    // CNT=4 directed vectors.
    apply(4, {8'h44, 8'h33, 8'h22, 8'h11}, 4'b1100, 8'h33, 1'b1, "c4_sel1100");
    apply(4, {8'h44, 8'h33, 8'h22, 8'h11}, 4'b1000, 8'h44, 1'b1, "c4_sel1000");
    apply(4, {8'h44, 8'h33, 8'h22, 8'h11}, 4'b0000, 8'h00, 1'b0, "c4_sel0000");
    apply(4, {8'h44, 8'h33, 8'h22, 8'h11}, 4'b0110, 8'h22, 1'b1, "c4_sel0110");
    apply(4, {8'h44, 8'h33, 8'h22, 8'h11}, 4'b1111, 8'h11, 1'b1, "c4_sel1111");
    sel_x = 4'bxxx1;
    apply(4, {8'h44, 8'h33, 8'h22, 8'h11}, sel_x, 8'h11, 1'b1, "c4_x_low_prio");

    // CNT=1.
    apply(1, {24'h0, 8'h5A}, 4'b0001, 8'h5A, 1'b1, "c1_sel1");
    apply(1, {24'h0, 8'h5A}, 4'b0000, 8'h00, 1'b0, "c1_sel0");

    // Reset pulse with sel=10 held on the CNT=2 unit.
    apply(2, {16'h0, 8'hA5, 8'h3C}, 4'b0010, 8'hA5, 1'b1, "rst_pre");
    idle();
    idle();
    probe_chk(2, 1'b0, REG_BUILD ? 8'h00 : 8'hA5, REG_BUILD ? 1'b0 : 1'b1, "rst_assert_now");
    probe_chk(2, 1'b0, REG_BUILD ? 8'h00 : 8'hA5, REG_BUILD ? 1'b0 : 1'b1, "rst_held_edge");
    probe_chk(2, 1'b1, REG_BUILD ? 8'h00 : 8'hA5, REG_BUILD ? 1'b0 : 1'b1, "rst_release_no_edge");
    probe_chk(2, 1'b1, 8'hA5, 1'b1, "rst_first_edge_after");
    idle();
    idle();
    done = 1'b1;
  end

  // Watchdog so the run always ends.
  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
